// File: rtl/mem_arb_rr.sv
// Shared single-port data memory arbitrated among CORE_CNT cores.
// Each edge serves one access, chosen by fixed slot rotation (MODE=0) or work-conserving round robin (MODE=1).
module mem_arb_rr #(
    parameter int unsigned CORE_CNT = 16,
    parameter int unsigned DATA_WID = 32,
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned MODE     = 1,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(CORE_CNT),
    localparam int unsigned BW = DATA_WID / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CORE_CNT-1:0]          req,
    input  logic [CORE_CNT-1:0]          we,
    input  logic [CORE_CNT*BW-1:0]       be,
    input  logic [CORE_CNT*AW-1:0]       addr,
    input  logic [CORE_CNT*DATA_WID-1:0] wdata,
    output logic [CORE_CNT-1:0]          gnt,
    output logic [CORE_CNT-1:0]          rvalid,
    output logic [DATA_WID-1:0]          rdata,
    output logic [CW-1:0]                slot
);

    logic [DATA_WID-1:0] mem [DEPTH];

    logic                gnt_vld_c;
    logic [CW-1:0]       win_c;
    logic [CW-1:0]       idx_c;
    logic [CW-1:0]       slot_nxt_c;
    logic [AW-1:0]       a_c;
    logic [BW-1:0]       be_c;
    logic [DATA_WID-1:0] wd_c;
    logic                wr_c;
    logic                rd_c;

    // Winner selection: first requester at or after the slot pointer
    always_comb begin
        gnt_vld_c = 1'b0;
        win_c     = '0;
        idx_c     = '0;
        if (MODE == 0) begin
            if (req[slot]) begin
                gnt_vld_c = 1'b1;
                win_c     = slot;
            end
        end else begin
            for (int unsigned i = 0; i < CORE_CNT; i++) begin
                idx_c = CW'((32'(slot) + i) % CORE_CNT);
                if (!gnt_vld_c && req[idx_c]) begin
                    gnt_vld_c = 1'b1;
                    win_c     = idx_c;
                end
            end
        end
    end

    // Grant and payload mux for the winning core; nothing is granted while in reset
    always_comb begin
        gnt = '0;
        if (gnt_vld_c && rst) begin
            gnt[win_c] = 1'b1;
        end
        a_c  = addr[32'(win_c)*AW +: AW];
        be_c = be[32'(win_c)*BW +: BW];
        wd_c = wdata[32'(win_c)*DATA_WID +: DATA_WID];
        wr_c = gnt_vld_c && rst && we[win_c];
        rd_c = gnt_vld_c && rst && !we[win_c];
    end

    always_comb begin
        slot_nxt_c = slot;
        if (MODE == 0) begin
            slot_nxt_c = (slot == CW'(CORE_CNT - 1)) ? '0 : slot + CW'(1);
        end else if (gnt_vld_c) begin
            slot_nxt_c = (win_c == CW'(CORE_CNT - 1)) ? '0 : win_c + CW'(1);
        end
    end

    // Byte-masked write port; RAM contents are not reset
    always_ff @(posedge clk) begin
        if (wr_c) begin
            for (int unsigned b = 0; b < BW; b++) begin
                if (be_c[b]) begin
                    mem[a_c][b*8 +: 8] <= wd_c[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot   <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            slot   <= slot_nxt_c;
            rvalid <= rd_c ? gnt : '0;
            if (rd_c) begin
                rdata <= mem[a_c];
            end
        end
    end

endmodule
